// File: rtl/tcdm_multiport_responder.sv
// Multi-port TCDM responder over a word-interleaved banked SRAM.
// Per-bank round-robin arbitration, fixed one-cycle response.
module tcdm_multiport_responder #(
    parameter int MP         = 4,
    parameter int N_BANKS    = 8,
    parameter int BANK_WORDS = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [MP-1:0]        tcdm_req,
    output logic [MP-1:0]        tcdm_gnt,
    input  logic [MP-1:0][31:0]  tcdm_add,
    input  logic [MP-1:0]        tcdm_wen,
    input  logic [MP-1:0][3:0]   tcdm_be,
    input  logic [MP-1:0][31:0]  tcdm_data,
    output logic [MP-1:0][31:0]  tcdm_r_data,
    output logic [MP-1:0]        tcdm_r_valid,
    input  logic [MP-1:0]        stall_i,
    input  logic                 clear_i,
    output logic [31:0]          conflict_cnt_o
);

    localparam int SH = $clog2(N_BANKS);
    localparam int BW = (N_BANKS > 1) ? SH : 1;
    localparam int RW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int PW = (MP > 1) ? $clog2(MP) : 1;

    logic [31:0]   mem [N_BANKS][BANK_WORDS];
    logic [BW-1:0] bank_of [MP];
    logic [RW-1:0] row_of [MP];
    logic [PW-1:0] rr_q [N_BANKS];
    logic [PW-1:0] bank_sel [N_BANKS];
    logic [N_BANKS-1:0] bank_vld;
    logic [MP-1:0] elig;
    logic          conflict;
    logic [31:0]   cnt_q;
    logic          unused_addr;

    // Upper address bits beyond the array size wrap silently.
    always_comb begin
        unused_addr = 1'b0;
        for (int p = 0; p < MP; p++) begin
            bank_of[p] = (N_BANKS > 1) ? BW'(tcdm_add[p][31:2]) : '0;
            row_of[p]  = (BANK_WORDS > 1) ? RW'(tcdm_add[p][31:2] >> SH) : '0;
            unused_addr = unused_addr ^ (^tcdm_add[p][1:0]);
        end
    end

    // Nothing is granted while reset is held, so no write or response
    // can originate from a reset cycle.
    assign elig = tcdm_req & ~stall_i & {MP{~rst_i}};

    always_comb begin
        int idx;
        idx      = 0;
        tcdm_gnt = '0;
        bank_vld = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            bank_sel[b] = '0;
            for (int o = 0; o < MP; o++) begin
                idx = (int'(rr_q[b]) + o) % MP;
                if (!bank_vld[b] && elig[idx] && bank_of[idx] == BW'(b)) begin
                    bank_vld[b]   = 1'b1;
                    bank_sel[b]   = PW'(idx);
                    tcdm_gnt[idx] = 1'b1;
                end
            end
        end
    end

    // Any eligible port left ungranted lost to another port on its bank.
    assign conflict = |(elig & ~tcdm_gnt);

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < N_BANKS; b++) begin
            if (bank_vld[b] && !tcdm_wen[bank_sel[b]]) begin
                for (int i = 0; i < 4; i++) begin
                    if (tcdm_be[bank_sel[b]][i])
                        mem[b][row_of[bank_sel[b]]][8*i +: 8] <=
                            tcdm_data[bank_sel[b]][8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < N_BANKS; b++)
                rr_q[b] <= '0;
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (bank_vld[b])
                    rr_q[b] <= (int'(bank_sel[b]) == MP - 1) ? '0 : bank_sel[b] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcdm_r_valid <= '0;
            tcdm_r_data  <= '0;
        end else begin
            tcdm_r_valid <= tcdm_gnt;
            for (int p = 0; p < MP; p++) begin
                if (tcdm_gnt[p])
                    tcdm_r_data[p] <= tcdm_wen[p] ? mem[bank_of[p]][row_of[p]] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (clear_i)
            cnt_q <= '0;
        else if (conflict && cnt_q != 32'hFFFF_FFFF)
            cnt_q <= cnt_q + 32'd1;
    end

    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_tcdm_multiport_responder.sv
// Scoreboard bench for tcdm_multiport_responder.
// Responses are predicted from a word-level memory model.
module tb_tcdm_multiport_responder;

    localparam int MP  = 4;
    localparam int NB  = 8;
    localparam int BWD = 1024;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [MP-1:0]       req = '0;
    logic [MP-1:0]       gnt;
    logic [MP-1:0][31:0] add = '0;
    logic [MP-1:0]       wen = '0;
    logic [MP-1:0][3:0]  be = '0;
    logic [MP-1:0][31:0] data = '0;
    logic [MP-1:0][31:0] r_data;
    logic [MP-1:0]       r_valid;
    logic [MP-1:0]       stall = '0;
    logic                clear = 1'b0;
    logic [31:0]         cnt;

    always #5 clk = ~clk;

    tcdm_multiport_responder #(
        .MP(MP), .N_BANKS(NB), .BANK_WORDS(BWD)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .tcdm_req(req), .tcdm_gnt(gnt),
        .tcdm_add(add), .tcdm_wen(wen),
        .tcdm_be(be), .tcdm_data(data),
        .tcdm_r_data(r_data), .tcdm_r_valid(r_valid),
        .stall_i(stall), .clear_i(clear),
        .conflict_cnt_o(cnt)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [MP][$];
    logic [MP-1:0] g_seen;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) & 32'(NB * BWD - 1));
    endfunction

    task automatic set_port(int p, logic w, logic [31:0] a,
                            logic [3:0] b, logic [31:0] d);
        req[p] = 1'b1; wen[p] = w; add[p] = a; be[p] = b; data[p] = d;
    endtask

    // Snapshot grants, predict responses, clock once, compare responses.
    task automatic step();
        logic [31:0] v;
        int k;
        #1;
        g_seen = gnt;
        for (int p = 0; p < MP; p++) begin
            if (g_seen[p]) begin
                k = widx(add[p]);
                if (wen[p]) exp_q[p].push_back(model.exists(k) ? model[k] : 32'hx);
                else        exp_q[p].push_back(32'h0);
            end
        end
        for (int p = 0; p < MP; p++) begin
            if (g_seen[p] && !wen[p]) begin
                k = widx(add[p]);
                v = model.exists(k) ? model[k] : 32'hx;
                for (int i = 0; i < 4; i++)
                    if (be[p][i]) v[8*i +: 8] = data[p][8*i +: 8];
                model[k] = v;
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < MP; p++) begin
            check($sformatf("rvalid%0d", p), 32'(r_valid[p]),
                  32'(exp_q[p].size() > 0));
            if (r_valid[p] && exp_q[p].size() > 0)
                check($sformatf("rdata%0d", p), r_data[p], exp_q[p].pop_front());
        end
    endtask

    initial begin
        logic [MP-1:0] g;

        for (int p = 0; p < MP; p++)
            set_port(p, 1'b0, 32'(4 * p), 4'hF, 32'h11 * (p + 1));
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", 32'(r_valid), 32'h0);
        check("rst_cnt", cnt, 32'h0);
        for (int p = 0; p < MP; p++)
            check($sformatf("rst_rdata%0d", p), r_data[p], 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1 check("gnt_wr_par", 32'(gnt), 32'hF);
        step();

        for (int p = 0; p < MP; p++)
            set_port(p, 1'b1, 32'(4 * p), 4'h0, 32'h0);
        #1 check("gnt_rd_par", 32'(gnt), 32'hF);
        step();
        for (int p = 0; p < MP; p++)
            check($sformatf("par_data%0d", p), r_data[p], 32'h11 * (p + 1));

        req = '0;
        set_port(3, 1'b0, 32'h20, 4'hF, 32'hCAFE_0020);
        #1 check("gnt_wr20", 32'(gnt), 32'h8);
        step();
        check("cnt_pre_conf", cnt, 32'h0);
        for (int p = 0; p < MP; p++)
            set_port(p, 1'b1, 32'h20, 4'h0, 32'h0);
        for (int i = 0; i < MP; i++) begin
            #1 check($sformatf("conf_gnt%0d", i), 32'(gnt), 32'(1 << i));
            g = gnt;
            step();
            req = req & ~g;
        end
        check("conf_cnt", cnt, 32'd3);

        req = '0;
        set_port(0, 1'b0, 32'h40, 4'hF, 32'hAABB_CCDD);
        step();
        set_port(0, 1'b0, 32'h40, 4'b0101, 32'h1122_3344);
        step();
        set_port(0, 1'b1, 32'h40, 4'h0, 32'h0);
        step();
        check("be_merge", r_data[0], 32'hAA22_CC44);

        for (int p = 0; p < MP; p++)
            set_port(p, 1'b1, 32'(4 * p), 4'h0, 32'h0);
        stall = 4'b0010;
        #1 check("stall_gnt", 32'(gnt), 32'hD);
        step();
        check("stall_cnt", cnt, 32'd3);
        req = 4'b0010;
        stall = '0;
        #1 check("unstall_gnt", 32'(gnt), 32'h2);
        step();
        req = '0;
        set_port(0, 1'b1, 32'h8000, 4'h0, 32'h0);
        step();
        check("wrap_data", r_data[0], 32'h11);

        req = '0;
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        set_port(0, 1'b1, 32'h0, 4'h0, 32'h0);
        set_port(1, 1'b1, 32'h20, 4'h0, 32'h0);
        #1 check("sat_gnt", 32'(gnt), 32'h2);
        step();
        check("cnt_sat", cnt, 32'hFFFF_FFFF);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("cnt_clear", cnt, 32'h0);
        step();
        check("cnt_after_clr", cnt, 32'd1);
        req = '0;
        step();

        for (int p = 0; p < MP; p++)
            check($sformatf("q_empty%0d", p), 32'(exp_q[p].size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
